// File: rtl/soc_dmem_dma.sv
// ----------------------------------------------------------------------------
// soc_dmem_dma
// Block-copy / block-fill engine that owns port B of the dual-port DMEM
// wrapper. The CPU keeps port A; this engine moves or initialises word blocks
// in the background.
//
// Ports
//   mclk, puc_rst          clock (rising edge), async active-high reset
//   start, mode            1-cycle request (accepted in IDLE), 0=copy 1=fill
//   src_addr, dst_addr     start word addresses, sampled at start
//   len, fill_val          word count (0 allowed) and fill pattern
//   abort                  end the transfer after the current cycle
//   busy, done, aborted    status: busy during RD/CAP/WR, done 1-cycle pulse,
//                          aborted held until the next accepted start
//   words_left             remaining word count
//   enb, web, addrb, dinb  RAM port B controls (Moore-decoded)
//   doutb                  RAM port B read data, valid the cycle after a read
// ----------------------------------------------------------------------------
module soc_dmem_dma #(
    parameter int ADDR_W = 12,
    parameter int LEN_W  = 12
) (
    input  logic              mclk,
    input  logic              puc_rst,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  len,
    input  logic [15:0]       fill_val,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_left,
    output logic              enb,
    output logic [1:0]        web,
    output logic [ADDR_W-1:0] addrb,
    output logic [15:0]       dinb,
    input  logic [15:0]       doutb
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_CAP  = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              r_aborted;
    logic [LEN_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic              r_mode;
    logic [15:0]       r_fill;
    logic [15:0]       r_data;

    logic w_accept;
    logic w_active;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_active = (r_state == S_RD) || (r_state == S_CAP) || (r_state == S_WR);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len == '0)
                        w_state_nxt = S_FIN;
                    else if (mode)
                        w_state_nxt = S_WR;
                    else
                        w_state_nxt = S_RD;
                end
            end
            S_RD:  w_state_nxt = abort ? S_FIN : S_CAP;
            S_CAP: w_state_nxt = abort ? S_FIN : S_WR;
            S_WR: begin
                // The count is checked before its decrement: 1 means this is the last word.
                if (abort || (r_cnt == LEN_W'(1)))
                    w_state_nxt = S_FIN;
                else if (r_mode)
                    w_state_nxt = S_WR;
                else
                    w_state_nxt = S_RD;
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Control state: the only registers that need reset values
    always_ff @(posedge mclk or posedge puc_rst) begin
        if (puc_rst) begin
            r_state   <= S_IDLE;
            r_aborted <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_aborted <= 1'b0;
                r_cnt     <= len;
            end else begin
                if (r_state == S_WR)
                    r_cnt <= r_cnt - LEN_W'(1);
                if (w_active && abort)
                    r_aborted <= 1'b1;
            end
        end
    end

    // Datapath: addresses wrap naturally modulo 2**ADDR_W
    always_ff @(posedge mclk) begin
        if (w_accept) begin
            r_src  <= src_addr;
            r_dst  <= dst_addr;
            r_mode <= mode;
            r_fill <= fill_val;
        end else begin
            if (r_state == S_CAP)
                r_data <= doutb;
            if (r_state == S_WR) begin
                r_dst <= r_dst + ADDR_W'(1);
                if (!r_mode)
                    r_src <= r_src + ADDR_W'(1);
            end
        end
    end

    // Moore decode of the RAM port and status outputs
    assign enb        = (r_state == S_RD) || (r_state == S_WR);
    assign web        = (r_state == S_WR) ? 2'b11 : 2'b00;
    assign addrb      = (r_state == S_RD) ? r_src :
                        (r_state == S_WR) ? r_dst : '0;
    assign dinb       = (r_state == S_WR) ? (r_mode ? r_fill : r_data) : 16'h0000;
    assign busy       = w_active;
    assign done       = (r_state == S_FIN);
    assign aborted    = r_aborted;
    assign words_left = r_cnt;

endmodule

// File: tb/tb_soc_dmem_dma.sv
module tb_soc_dmem_dma;

    logic        mclk = 1'b0;
    logic        puc_rst;
    logic        start;
    logic        mode;
    logic [11:0] src_addr;
    logic [11:0] dst_addr;
    logic [11:0] len;
    logic [15:0] fill_val;
    logic        abort;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [11:0] words_left;
    logic        enb;
    logic [1:0]  web;
    logic [11:0] addrb;
    logic [15:0] dinb;
    logic [15:0] doutb;

    int tests = 0;
    int fails = 0;

    logic [15:0] mem [0:4095];
    logic [11:0] wr_log [$];
    int          enb_cnt = 0;

    always #5 mclk = ~mclk;

    soc_dmem_dma #(.ADDR_W(12), .LEN_W(12)) dut (
        .mclk(mclk), .puc_rst(puc_rst), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .words_left(words_left), .enb(enb), .web(web), .addrb(addrb),
        .dinb(dinb), .doutb(doutb)
    );

    // Synchronous RAM model for port B: registered read, write on web=11
    always @(posedge mclk) begin
        if (enb) begin
            enb_cnt++;
            doutb <= mem[addrb];
            if (web == 2'b11) begin
                mem[addrb] = dinb;
                wr_log.push_back(addrb);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen by the next rising edge.
    task automatic kick(input logic m, input logic [11:0] s, input logic [11:0] d,
                        input logic [11:0] l, input logic [15:0] f);
        start = 1'b1; mode = m; src_addr = s; dst_addr = d; len = l; fill_val = f;
        @(posedge mclk);
        @(negedge mclk);
        start = 1'b0;
    endtask

    // Returns the cycle (counted from start) at which done is seen.
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!done && cyc < 200) begin
            @(posedge mclk);
            @(negedge mclk);
            cyc++;
        end
    endtask

    int c;
    int base;
    int e0;

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        puc_rst = 1'b1; start = 1'b0; mode = 1'b0; src_addr = '0; dst_addr = '0;
        len = '0; fill_val = '0; abort = 1'b0;
        repeat (3) @(negedge mclk);

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_enb", enb, 0);
        chk("rst_web", web, 0);
        chk("rst_addrb", addrb, 0);
        chk("rst_dinb", dinb, 0);
        chk("rst_words_left", words_left, 0);
        puc_rst = 1'b0;
        @(negedge mclk);

        // Copy 4 words 0x010 -> 0x100
        mem[12'h010] = 16'h1111; mem[12'h011] = 16'h2222;
        mem[12'h012] = 16'h3333; mem[12'h013] = 16'h4444;
        kick(1'b0, 12'h010, 12'h100, 12'd4, 16'h0);
        chk("copy_c1_busy", busy, 1);
        chk("copy_c1_enb", enb, 1);
        chk("copy_c1_web", web, 2'b00);
        chk("copy_c1_addrb", addrb, 12'h010);
        chk("copy_c1_words_left", words_left, 4);
        wait_done(c);
        chk("copy_done_cycle", c, 13);
        chk("copy_aborted", aborted, 0);
        chk("copy_words_left", words_left, 0);
        chk("copy_fin_busy", busy, 0);
        chk("copy_w0", mem[12'h100], 16'h1111);
        chk("copy_w1", mem[12'h101], 16'h2222);
        chk("copy_w2", mem[12'h102], 16'h3333);
        chk("copy_w3", mem[12'h103], 16'h4444);
        @(negedge mclk);
        chk("copy_done_pulse", done, 0);

        // Fill 8 words at 0x200; a start pulsed mid-transfer must be ignored
        base = wr_log.size();
        kick(1'b1, 12'h000, 12'h200, 12'd8, 16'hA5A5);
        chk("fill_c1_web", web, 2'b11);
        chk("fill_c1_dinb", dinb, 16'hA5A5);
        @(posedge mclk); @(negedge mclk);
        @(posedge mclk); @(negedge mclk);
        start = 1'b1; mode = 1'b1; dst_addr = 12'h700; len = 12'd0; fill_val = 16'hDEAD;
        @(posedge mclk); @(negedge mclk);
        start = 1'b0;
        c = 4;
        while (!done && c < 200) begin
            @(posedge mclk); @(negedge mclk); c++;
        end
        chk("fill_done_cycle", c, 9);
        chk("fill_write_count", wr_log.size() - base, 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("fill_addr%0d", i), wr_log[base + i], 12'h200 + 12'(i));
            chk($sformatf("fill_data%0d", i), mem[12'h200 + 12'(i)], 16'hA5A5);
        end
        chk("fill_ignored_start", mem[12'h700], 16'h0000);
        @(negedge mclk);

        // len = 0: no RAM access, done one cycle later
        e0 = enb_cnt;
        kick(1'b1, 12'h0, 12'h300, 12'd0, 16'h1234);
        chk("len0_done", done, 1);
        chk("len0_busy", busy, 0);
        chk("len0_aborted", aborted, 0);
        chk("len0_enb_count", enb_cnt - e0, 0);
        @(negedge mclk);

        // Address wrap on fill
        base = wr_log.size();
        kick(1'b1, 12'h0, 12'hFFE, 12'd4, 16'h5A5A);
        wait_done(c);
        chk("wrap_done_cycle", c, 5);
        chk("wrap_count", wr_log.size() - base, 4);
        chk("wrap_a0", wr_log[base + 0], 12'hFFE);
        chk("wrap_a1", wr_log[base + 1], 12'hFFF);
        chk("wrap_a2", wr_log[base + 2], 12'h000);
        chk("wrap_a3", wr_log[base + 3], 12'h001);
        chk("wrap_d2", mem[12'h000], 16'h5A5A);
        @(negedge mclk);

        // Abort during the 3rd WR of a 10-word copy
        for (int i = 0; i < 10; i++) mem[12'h400 + 12'(i)] = 16'h3000 + 16'(i);
        base = wr_log.size();
        kick(1'b0, 12'h400, 12'h500, 12'd10, 16'h0);
        repeat (8) begin @(posedge mclk); @(negedge mclk); end
        chk("abort_in_wr_web", web, 2'b11);
        chk("abort_in_wr_addr", addrb, 12'h502);
        abort = 1'b1;
        @(posedge mclk); @(negedge mclk);
        abort = 1'b0;
        chk("abort_done", done, 1);
        chk("abort_flag", aborted, 1);
        chk("abort_words_left", words_left, 7);
        chk("abort_write_count", wr_log.size() - base, 3);
        chk("abort_w2", mem[12'h502], 16'h3002);
        chk("abort_w3_untouched", mem[12'h503], 16'h0000);
        @(negedge mclk);
        chk("abort_held", aborted, 1);
        chk("abort_done_cleared", done, 0);
        kick(1'b1, 12'h0, 12'h520, 12'd1, 16'h0BEE);
        chk("after_abort_busy", busy, 1);
        chk("after_abort_cleared", aborted, 0);
        wait_done(c);
        chk("after_abort_done_cycle", c, 2);
        chk("after_abort_data", mem[12'h520], 16'h0BEE);
        @(negedge mclk);

        // Async reset on the 2nd WR of a fill
        base = wr_log.size();
        kick(1'b1, 12'h0, 12'h600, 12'd8, 16'h7777);
        @(posedge mclk); @(negedge mclk);
        chk("arst_pre_enb", enb, 1);
        #1 puc_rst = 1'b1;
        #1;
        chk("arst_enb", enb, 0);
        chk("arst_web", web, 0);
        chk("arst_busy", busy, 0);
        chk("arst_words_left", words_left, 0);
        @(negedge mclk);
        chk("arst_no_done", done, 0);
        puc_rst = 1'b0;
        @(negedge mclk);
        chk("arst_no_done_after", done, 0);
        chk("arst_write_count", wr_log.size() - base, 1);
        chk("arst_partial", mem[12'h601], 16'h0000);
        kick(1'b1, 12'h0, 12'h610, 12'd2, 16'h4321);
        wait_done(c);
        chk("arst_restart_cycle", c, 3);
        chk("arst_restart_d1", mem[12'h611], 16'h4321);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
